// File: rtl/traffic_phase_controller.sv
// Two-lane traffic light sequencer: one-second prescaler, four-phase light cycle,
// lane countdowns, and run/config arbitration with validated time latching.
module traffic_phase_controller #(
  parameter int unsigned CLK_PER_SEC    = 100,
  parameter int unsigned DEFAULT_GREEN  = 27,
  parameter int unsigned DEFAULT_YELLOW = 3,
  parameter int unsigned DEFAULT_RED    = 30,
  parameter int unsigned MAX_TIME       = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       buttonMode,
  input  logic [6:0] greenTimeIn,
  input  logic [6:0] yellowTimeIn,
  input  logic [6:0] redTimeIn,
  output logic       configEnable,
  output logic [6:0] greenTime,
  output logic [6:0] yellowTime,
  output logic [6:0] redTime,
  output logic [2:0] lightLane1,
  output logic [2:0] lightLane2,
  output logic [6:0] timeLane1,
  output logic [6:0] timeLane2,
  output logic       tick
);

  localparam int unsigned TW = 7;
  localparam int unsigned PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  typedef enum logic [2:0] {
    P_GR   = 3'd0,
    P_YR   = 3'd1,
    P_RG   = 3'd2,
    P_RY   = 3'd3,
    CONFIG = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] green_q, green_d;
  logic [TW-1:0] yellow_q, yellow_d;
  logic [TW-1:0] red_q, red_d;

  logic sec_end;
  logic cfg_valid;

  assign sec_end = (presc_q == PW'(CLK_PER_SEC - 1));

  // Sum computed one bit wider so an overflowing green+yellow cannot alias a legal red
  assign cfg_valid = (greenTimeIn != '0) && (yellowTimeIn != '0) &&
                     (redTimeIn <= TW'(MAX_TIME)) &&
                     ((8'(greenTimeIn) + 8'(yellowTimeIn)) == 8'(redTimeIn));

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= P_GR;
      cnt_q    <= TW'(DEFAULT_GREEN);
      presc_q  <= '0;
      green_q  <= TW'(DEFAULT_GREEN);
      yellow_q <= TW'(DEFAULT_YELLOW);
      red_q    <= TW'(DEFAULT_RED);
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      presc_q  <= presc_d;
      green_q  <= green_d;
      yellow_q <= yellow_d;
      red_q    <= red_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    presc_d  = presc_q;
    green_d  = green_q;
    yellow_d = yellow_q;
    red_d    = red_q;

    case (state_q)
      P_GR, P_YR, P_RG, P_RY: begin
        if (buttonMode) begin
          // Mode request wins over a coincident tick; counters freeze
          state_d = CONFIG;
        end else begin
          presc_d = sec_end ? '0 : PW'(presc_q + 1'b1);
          if (sec_end) begin
            if (cnt_q == TW'(1)) begin
              case (state_q)
                P_GR:    begin state_d = P_YR; cnt_d = yellow_q; end
                P_YR:    begin state_d = P_RG; cnt_d = green_q;  end
                P_RG:    begin state_d = P_RY; cnt_d = yellow_q; end
                default: begin state_d = P_GR; cnt_d = green_q;  end
              endcase
            end else begin
              cnt_d = TW'(cnt_q - 1'b1);
            end
          end
        end
      end
      CONFIG: begin
        if (buttonMode) begin
          state_d = P_GR;
          presc_d = '0;
          if (cfg_valid) begin
            green_d  = greenTimeIn;
            yellow_d = yellowTimeIn;
            red_d    = redTimeIn;
            cnt_d    = greenTimeIn;
          end else begin
            cnt_d    = green_q;
          end
        end
      end
      default: begin
        state_d = P_GR;
        cnt_d   = green_q;
        presc_d = '0;
      end
    endcase
  end

  // Lamp and countdown decode straight from registered state
  always_comb begin
    configEnable = 1'b0;
    lightLane1   = LAMP_OFF;
    lightLane2   = LAMP_OFF;
    timeLane1    = '0;
    timeLane2    = '0;
    tick         = 1'b0;

    case (state_q)
      P_GR: begin
        lightLane1 = LAMP_G;
        lightLane2 = LAMP_R;
        timeLane1  = cnt_q;
        timeLane2  = TW'(cnt_q + yellow_q);
        tick       = sec_end;
      end
      P_YR: begin
        lightLane1 = LAMP_Y;
        lightLane2 = LAMP_R;
        timeLane1  = cnt_q;
        timeLane2  = cnt_q;
        tick       = sec_end;
      end
      P_RG: begin
        lightLane1 = LAMP_R;
        lightLane2 = LAMP_G;
        timeLane1  = TW'(cnt_q + yellow_q);
        timeLane2  = cnt_q;
        tick       = sec_end;
      end
      P_RY: begin
        lightLane1 = LAMP_R;
        lightLane2 = LAMP_Y;
        timeLane1  = cnt_q;
        timeLane2  = cnt_q;
        tick       = sec_end;
      end
      CONFIG: begin
        configEnable = 1'b1;
      end
      default: begin
        configEnable = 1'b0;
      end
    endcase
  end

  assign greenTime  = green_q;
  assign yellowTime = yellow_q;
  assign redTime    = red_q;

endmodule
